// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the async FIFO read-side blocks.
//   - FIFO_DATA_W : default data width of memory read data and output stream
//   - FIFO_BUF_D  : depth of the FWFT output buffer (the design relies on 2)
//   - level_t     : buffer occupancy type (0..2)
//   - occupancy() : words held, plus the word arriving, minus the word leaving
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int unsigned FIFO_DATA_W = 8;
   localparam int unsigned FIFO_BUF_D  = 2;

   typedef logic [1:0] level_t;

   // One bit of headroom, so that a full buffer plus an arriving word (3)
   // is still representable and can be caught by the overflow check.
   function automatic logic [2:0] occupancy(input level_t count,
                                            input logic   add,
                                            input logic   sub);
      return {1'b0, count} + {2'b00, add} - {2'b00, sub};
   endfunction

endpackage

// File: rtl/fwft_buf2.sv
// -----------------------------------------------------------------------------
// fwft_buf2
//   Two-entry shift buffer. Entry 0 is the head. A dequeue shifts entry 1
//   into entry 0. A write lands in the first free slot that remains after
//   the dequeue of this cycle, so a write and a dequeue can share a cycle.
//
// Ports
//   clk_i    in   1       clock, posedge
//   rst_i    in   1       synchronous active-high reset (empties the buffer)
//   wr_i     in   1       write wdata_i this cycle
//   wdata_i  in   DATA_W  write data
//   deq_i    in   1       remove the head this cycle (ignored when empty)
//   head_o   out  DATA_W  registered head entry (zero after reset)
//   count_o  out  2       registered number of entries held (0..2)
// -----------------------------------------------------------------------------
module fwft_buf2
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              deq_i,
   output logic [DATA_W-1:0] head_o,
   output level_t            count_o
);

   logic [DATA_W-1:0] buf0_q, buf0_d;
   logic [DATA_W-1:0] buf1_q, buf1_d;
   level_t            count_q, count_d;
   logic              deq_eff;
   level_t            slot;
   logic [2:0]        count_nxt;

   always_comb begin
      deq_eff   = deq_i & (count_q != 2'd0);
      // Slot index after the dequeue shift: with one word held and one
      // leaving, the new word becomes the head.
      slot      = count_q - {1'b0, deq_eff};
      count_nxt = occupancy(count_q, wr_i, deq_eff);
      count_d   = count_nxt[1:0];

      buf0_d = buf0_q;
      buf1_d = buf1_q;
      if (deq_eff) begin
         buf0_d = buf1_q;
      end
      if (wr_i) begin
         if (slot == 2'd0) begin
            buf0_d = wdata_i;
         end else begin
            buf1_d = wdata_i;
         end
      end
   end

   // Head entry and count: reset so that the stream output reads as zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         buf0_q  <= '0;
      end else begin
         count_q <= count_d;
         buf0_q  <= buf0_d;
         // Upstream credit logic must never let a third word arrive.
         assert (count_nxt <= 3'd2);
      end
   end

   // Second entry is pure data: only meaningful while count_q == 2.
   always_ff @(posedge clk_i) begin
      buf1_q <= buf1_d;
   end

   assign head_o  = buf0_q;
   assign count_o = count_q;

endmodule

// File: rtl/rd_fwft_stage.sv
// -----------------------------------------------------------------------------
// rd_fwft_stage
//   Read-side output stage of the async FIFO. Converts the pop interface of
//   the read-pointer block (empty in, rd_en out, memory data one cycle after
//   the pop) into a first-word-fall-through valid/ready stream, backed by a
//   two-entry output buffer. Sustains one word per cycle.
//
// Ports
//   rd_clk      in   1       read-domain clock, posedge
//   rd_rst      in   1       synchronous active-high reset
//   empty       in   1       registered empty flag from the read-pointer block
//   rd_en       out  1       pop request; a pop happens when rd_en & ~empty
//   mem_rdata   in   DATA_W  memory read data, valid the cycle after a pop
//   dout        out  DATA_W  head-of-buffer data (registered)
//   dout_valid  out  1       dout holds a valid word
//   dout_ready  in   1       consumer takes dout this cycle
//   buf_level   out  2       words currently held in the buffer (registered)
// -----------------------------------------------------------------------------
module rd_fwft_stage
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W,
   parameter int unsigned BUF_D  = FIFO_BUF_D
) (
   input  logic              rd_clk,
   input  logic              rd_rst,
   input  logic              empty,
   output logic              rd_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [1:0]        buf_level
);

   localparam logic [2:0] CREDITS = 3'(BUF_D);

   logic              inflight_q, inflight_d;
   logic              pop;
   logic              deq;
   level_t            count;
   logic [DATA_W-1:0] head;

   assign dout_valid = (count != 2'd0);
   assign deq        = dout_valid & dout_ready;

   // Credit check: a pop is requested only if the word it produces is sure
   // to find a free slot, counting the word already in flight and the word
   // leaving this cycle. Deliberately independent of empty; the pointer
   // block qualifies the request with its own flag.
   assign rd_en = ~rd_rst & (occupancy(count, inflight_q, deq) < CREDITS);
   assign pop   = rd_en & ~empty;

   always_comb begin
      inflight_d = pop;
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         // A real pop was issued last cycle, so the memory owes us data.
         if (inflight_q) begin
            assert (!$isunknown(mem_rdata));
         end
      end
   end

   // Memory data is captured into the buffer the cycle after its pop; the
   // buffer output is registered, so there is no path mem_rdata -> dout.
   fwft_buf2 #(
      .DATA_W (DATA_W)
   ) u_buf (
      .clk_i   (rd_clk),
      .rst_i   (rd_rst),
      .wr_i    (inflight_q),
      .wdata_i (mem_rdata),
      .deq_i   (deq),
      .head_o  (head),
      .count_o (count)
   );

   assign dout      = head;
   assign buf_level = count;

endmodule

// File: tb/tb_rd_fwft_stage.sv
module tb_rd_fwft_stage;

   localparam int DW = 8;

   logic          rd_clk = 1'b0;
   logic          rd_rst;
   logic          empty;
   logic          rd_en;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic [1:0]    buf_level;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 rd_clk = ~rd_clk;

   rd_fwft_stage #(.DATA_W(DW), .BUF_D(2)) dut (
      .rd_clk     (rd_clk),
      .rd_rst     (rd_rst),
      .empty      (empty),
      .rd_en      (rd_en),
      .mem_rdata  (mem_rdata),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .buf_level  (buf_level)
   );

   // Source model (read-pointer block + memory) and scoreboard queues.
   logic [DW-1:0] src_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   logic          pend;
   logic [DW-1:0] pend_w;
   int            cyc    = 0;
   int            n_pops = 0;

   logic          obs_valid, obs_rd_en, obs_pop;
   logic [DW-1:0] obs_dout;
   logic [1:0]    obs_level;

   // One clock cycle: sample at negedge, then drive after the posedge.
   task automatic cycle();
      @(negedge rd_clk);
      cyc++;
      obs_valid = dout_valid;
      obs_dout  = dout;
      obs_level = buf_level;
      obs_rd_en = rd_en;
      obs_pop   = rd_en & ~empty;
      if (dout_valid && dout_ready) got_q.push_back(dout);
      pend = 1'b0;
      if (obs_pop && src_q.size() != 0) begin
         pend_w = src_q.pop_front();
         exp_q.push_back(pend_w);
         pend = 1'b1;
         n_pops++;
      end
      @(posedge rd_clk);
      #1;
      mem_rdata = pend ? pend_w : DW'($urandom);
      empty     = (src_q.size() == 0);
   endtask

   task automatic flush_model();
      src_q.delete();
      exp_q.delete();
      got_q.delete();
      pend  = 1'b0;
      empty = 1'b1;
   endtask

   task automatic test_reset();
      rd_rst = 1'b1; dout_ready = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 4; i++) src_q.push_back(8'hEE);
      empty = 1'b0;
      cycle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_tests++; if (obs_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en cyc%0d got %b exp 0", i, obs_rd_en); end
         n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc%0d got %b exp 0", i, obs_valid); end
         n_tests++; if (obs_level !== 2'd0) begin n_fail++; $display("FAIL reset_level cyc%0d got %0d exp 0", i, obs_level); end
         n_tests++; if (obs_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout cyc%0d got %h exp 00", i, obs_dout); end
      end
      flush_model();
      rd_rst = 1'b0;
   endtask

   task automatic test_single();
      int p_cyc = -1;
      dout_ready = 1'b1;
      src_q.push_back(8'hA5);
      for (int i = 0; i < 10 && p_cyc < 0; i++) begin
         cycle();
         if (obs_pop) p_cyc = cyc;
      end
      n_tests++; if (p_cyc < 0) begin n_fail++; $display("FAIL single_pop got none exp 1 pop"); end
      cycle();
      n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_n1 got %b exp 0", obs_valid); end
      cycle();
      n_tests++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_n2 got %b exp 1", obs_valid); end
      n_tests++; if (obs_dout !== 8'hA5) begin n_fail++; $display("FAIL single_dout got %h exp a5", obs_dout); end
      n_tests++; if (obs_level !== 2'd1) begin n_fail++; $display("FAIL single_level_n2 got %0d exp 1", obs_level); end
      cycle();
      n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_n3 got %b exp 0", obs_valid); end
      n_tests++; if (obs_level !== 2'd0) begin n_fail++; $display("FAIL single_level_n3 got %0d exp 0", obs_level); end
      n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL single_count got %0d exp 1", got_q.size()); end
      foreach (got_q[i]) begin
         n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_sb[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_stream();
      int first = -1, last = -1, nvalid = 0, bad_level = 0;
      int fpop = -1, lpop = -1;
      dout_ready = 1'b1;
      for (int v = 0; v < 16; v++) src_q.push_back(8'(v));
      for (int i = 0; i < 60 && got_q.size() < 16; i++) begin
         cycle();
         if (obs_pop) begin
            if (fpop < 0) fpop = cyc;
            lpop = cyc;
         end
         if (obs_valid) begin
            if (first < 0) first = cyc;
            last = cyc;
            nvalid++;
            if (obs_level !== 2'd1) bad_level++;
         end
      end
      n_tests++; if (got_q.size() != 16) begin n_fail++; $display("FAIL stream_count got %0d exp 16", got_q.size()); end
      n_tests++; if (nvalid != 16) begin n_fail++; $display("FAIL stream_valid_cycles got %0d exp 16", nvalid); end
      n_tests++; if (last - first != 15) begin n_fail++; $display("FAIL stream_consecutive got span %0d exp 15", last - first); end
      n_tests++; if (lpop - fpop != 15) begin n_fail++; $display("FAIL stream_rd_en_held got pop span %0d exp 15", lpop - fpop); end
      n_tests++; if (bad_level != 0) begin n_fail++; $display("FAIL stream_level got %0d off-level cycles exp 0", bad_level); end
      foreach (got_q[i]) begin
         n_tests++; if (got_q[i] !== 8'(i)) begin n_fail++; $display("FAIL stream_data[%0d] got %h exp %h", i, got_q[i], 8'(i)); end
      end
      got_q.delete(); exp_q.delete();
      repeat (2) cycle();
   endtask

   task automatic test_backpressure();
      int p0 = n_pops, unstable = 0;
      logic          held_ok = 1'b0;
      logic [DW-1:0] held = '0;
      logic [DW-1:0] e;
      dout_ready = 1'b0;
      for (int i = 0; i < 6; i++) src_q.push_back(8'h40 + 8'(i));
      repeat (12) begin
         cycle();
         if (obs_valid) begin
            if (!held_ok) begin held = obs_dout; held_ok = 1'b1; end
            else if (obs_dout !== held) unstable++;
         end
      end
      n_tests++; if (n_pops - p0 != 2) begin n_fail++; $display("FAIL bp_pops got %0d exp 2", n_pops - p0); end
      n_tests++; if (obs_level !== 2'd2) begin n_fail++; $display("FAIL bp_level got %0d exp 2", obs_level); end
      n_tests++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b exp 1", obs_valid); end
      n_tests++; if (obs_dout !== 8'h40) begin n_fail++; $display("FAIL bp_head got %h exp 40", obs_dout); end
      n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable got %0d changes exp 0", unstable); end
      dout_ready = 1'b1;
      for (int i = 0; i < 40 && got_q.size() < 6; i++) cycle();
      repeat (3) cycle();
      n_tests++; if (got_q.size() != 6) begin n_fail++; $display("FAIL bp_count got %0d exp 6", got_q.size()); end
      foreach (got_q[i]) begin
         e = 8'h40 + 8'(i);
         n_tests++; if (got_q[i] !== e) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp %h", i, got_q[i], e); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_empty_flight();
      int p0 = n_pops;
      dout_ready = 1'b1;
      src_q.push_back(8'h3C);
      repeat (8) cycle();
      n_tests++; if (n_pops - p0 != 1) begin n_fail++; $display("FAIL ef_pops got %0d exp 1", n_pops - p0); end
      n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL ef_count got %0d exp 1", got_q.size()); end
      n_tests++; if (got_q.size() > 0 && got_q[0] !== 8'h3C) begin n_fail++; $display("FAIL ef_data got %h exp 3c", got_q[0]); end
      n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL ef_idle_valid got %b exp 0", obs_valid); end
      src_q.push_back(8'h5A);
      repeat (6) cycle();
      n_tests++; if (got_q.size() != 2) begin n_fail++; $display("FAIL ef_count2 got %0d exp 2", got_q.size()); end
      n_tests++; if (got_q.size() > 1 && got_q[1] !== 8'h5A) begin n_fail++; $display("FAIL ef_data2 got %h exp 5a", got_q[1]); end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int p0;
      logic reached = 1'b0;
      // Reset with a full buffer.
      dout_ready = 1'b0;
      for (int i = 0; i < 4; i++) src_q.push_back(8'h90 + 8'(i));
      for (int i = 0; i < 12 && !reached; i++) begin
         cycle();
         if (obs_level == 2'd2) reached = 1'b1;
      end
      n_tests++; if (!reached) begin n_fail++; $display("FAIL rm_fill got level %0d exp 2", obs_level); end
      rd_rst = 1'b1;
      cycle();
      n_tests++; if (obs_rd_en !== 1'b0) begin n_fail++; $display("FAIL rm_rd_en got %b exp 0", obs_rd_en); end
      rd_rst = 1'b0;
      flush_model();
      cycle();
      n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid_a got %b exp 0", obs_valid); end
      n_tests++; if (obs_level !== 2'd0) begin n_fail++; $display("FAIL rm_level_a got %0d exp 0", obs_level); end
      // Reset with one word held and one in flight.
      p0 = n_pops;
      for (int i = 0; i < 4; i++) src_q.push_back(8'hB0 + 8'(i));
      for (int i = 0; i < 12 && (n_pops - p0) < 2; i++) cycle();
      n_tests++; if (n_pops - p0 != 2) begin n_fail++; $display("FAIL rm_pops got %0d exp 2", n_pops - p0); end
      rd_rst = 1'b1;
      cycle();
      rd_rst = 1'b0;
      flush_model();
      cycle();
      n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid_b got %b exp 0", obs_valid); end
      n_tests++; if (obs_level !== 2'd0) begin n_fail++; $display("FAIL rm_level_b got %0d exp 0", obs_level); end
      dout_ready = 1'b1;
      repeat (4) cycle();
      n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rm_stale got %0d words exp 0", got_q.size()); end
      src_q.push_back(8'h77);
      for (int i = 0; i < 10 && got_q.size() < 1; i++) cycle();
      repeat (2) cycle();
      n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL rm_new_count got %0d exp 1", got_q.size()); end
      n_tests++; if (got_q.size() > 0 && got_q[0] !== 8'h77) begin n_fail++; $display("FAIL rm_new_data got %h exp 77", got_q[0]); end
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      rd_rst = 1'b1; empty = 1'b1; dout_ready = 1'b0; mem_rdata = '0; pend = 1'b0; pend_w = '0;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_empty_flight();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "timeout");
   end

endmodule
